// File: rtl/out_wb_pkg.sv
// Shared constants and helpers for the out_wb write-back stage.
// Build option RELU_OUT_EN: clamp outputs to [0,127] instead of [-128,127].
package out_wb_pkg;

    localparam int LANES  = 4;
    localparam int PSUM_W = 24;
    localparam int OUT_W  = 8;
    localparam int SH_W   = 5;
    localparam int BIAS_W = 32;
    localparam int SUM_W  = 33;
    localparam int IDX_W  = $clog2(LANES);

    localparam int OUT_MAX = (1 << (OUT_W - 1)) - 1;
`ifdef RELU_OUT_EN
    localparam int OUT_MIN = 0;
`else
    localparam int OUT_MIN = -(1 << (OUT_W - 1));
`endif

    function automatic logic signed [PSUM_W-1:0] psum_lane(
        input logic [LANES*PSUM_W-1:0] v,
        input int                      i
    );
        return v[i*PSUM_W +: PSUM_W];
    endfunction

endpackage

// File: rtl/requant_lane.sv
// One output lane: round-half-up arithmetic shift (S2), then clamp to the
// output range (S3). Range depends on RELU_OUT_EN through out_wb_pkg.
module requant_lane
    import out_wb_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load_r,
    input  logic                    load_q,
    input  logic [SH_W-1:0]         shift,
    input  logic signed [SUM_W-1:0] sum,
    output logic [OUT_W-1:0]        q
);

    localparam logic signed [SUM_W:0] LIM_HI = (SUM_W + 1)'(OUT_MAX);
    localparam logic signed [SUM_W:0] LIM_LO = (SUM_W + 1)'(OUT_MIN);

    logic signed [SUM_W:0] half;
    logic signed [SUM_W:0] rounded;
    logic signed [SUM_W:0] r_q;
    logic signed [SUM_W:0] clamped;

    // One extra bit keeps sum + half from overflowing; the shift never exceeds
    // 31, so the result always fits and large shifts collapse to the sign.
    always_comb begin
        half = '0;
        if (shift != '0) begin
            half[shift - 1'b1] = 1'b1;
        end
        rounded = ((SUM_W + 1)'(sum) + half) >>> shift;
    end

    always_comb begin
        clamped = r_q;
        if (r_q > LIM_HI) begin
            clamped = LIM_HI;
        end else if (r_q < LIM_LO) begin
            clamped = LIM_LO;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
            q   <= '0;
        end else begin
            if (load_r) begin
                r_q <= rounded;
            end
            if (load_q) begin
                q <= clamped[OUT_W-1:0];
            end
        end
    end

endmodule

// File: rtl/out_wb.sv
// Output write-back: bias add, requantize, pack 4 lanes, write with a
// 3-cycle fixed latency. Build option RELU_OUT_EN selects the ReLU clamp.
module out_wb
    import out_wb_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    mb_en,
    input  logic [31:0]             mb_R_data,
    input  logic [SH_W-1:0]         shift,
    input  logic                    psum_valid,
    input  logic                    psum_last,
    input  logic [LANES*PSUM_W-1:0] psum,
    input  logic [31:0]             addr_in,
    output logic [31:0]             Mout_addr,
    output logic [31:0]             Mout_W_data,
    output logic [3:0]              Mout_W_req,
    output logic                    bias_ready,
    output logic                    bias_err,
    output logic                    busy
);

    logic signed [BIAS_W-1:0] bias [LANES];
    logic [IDX_W-1:0]         bias_idx;
    logic                     accept;
    logic                     s1_valid, s2_valid, s3_valid;
    logic [31:0]              s1_addr, s2_addr;
    logic signed [SUM_W-1:0]  s1_sum [LANES];
    logic [OUT_W-1:0]         lane_q [LANES];

    // A beat arriving together with clear belongs to the abandoned layer.
    assign accept = psum_valid && psum_last && !clear;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            for (int i = 0; i < LANES; i++) begin
                bias[i] <= '0;
            end
            bias_idx   <= '0;
            bias_ready <= 1'b0;
            bias_err   <= 1'b0;
        end else begin
            if (mb_en) begin
                bias[bias_idx] <= mb_R_data;
                bias_idx       <= bias_idx + 1'b1;
                if (bias_idx == IDX_W'(LANES - 1)) begin
                    bias_ready <= 1'b1;
                end
            end
            if (accept && !bias_ready) begin
                bias_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s3_valid <= 1'b0;
        end else begin
            s1_valid <= accept;
            s2_valid <= s1_valid;
            s3_valid <= s2_valid;
        end
    end

    // Bias reads here see the pre-update registers when mb_en coincides.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LANES; i++) begin
                s1_sum[i] <= '0;
            end
            s1_addr   <= '0;
            s2_addr   <= '0;
            Mout_addr <= '0;
        end else begin
            if (accept) begin
                for (int i = 0; i < LANES; i++) begin
                    s1_sum[i] <= SUM_W'(psum_lane(psum, i)) + SUM_W'(bias[i]);
                end
                s1_addr <= addr_in;
            end
            if (s1_valid) begin
                s2_addr <= s1_addr;
            end
            if (s2_valid) begin
                Mout_addr <= s2_addr;
            end
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        requant_lane u_lane (
            .clk    (clk),
            .rst    (rst),
            .load_r (s1_valid),
            .load_q (s2_valid),
            .shift  (shift),
            .sum    (s1_sum[g]),
            .q      (lane_q[g])
        );
        assign Mout_W_data[g*OUT_W +: OUT_W] = lane_q[g];
    end

    assign Mout_W_req = {LANES{s3_valid}};
    assign busy       = s1_valid | s2_valid | s3_valid;

endmodule
